// File: rtl/vx_mem_arb_pkg.sv
// Shared types and helpers for the memory-share arbiter (vx_mem_share_arb and vx_rr_arbiter).
package vx_mem_arb_pkg;

  localparam int DEF_DATA_WIDTH   = 512;
  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_SIZE_WIDTH   = 3;
  localparam int DEF_TAG_IN_WIDTH = 8;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                          rw;
    logic [DEF_DATA_WIDTH/8-1:0]   byteen;
    logic [DEF_SIZE_WIDTH-1:0]     size;
    logic [DEF_ADDR_WIDTH-1:0]     addr;
    logic [DEF_DATA_WIDTH-1:0]     data;
    logic [DEF_TAG_IN_WIDTH-1:0]   tag;
  } req_t;

endpackage

// File: rtl/vx_mem_share_arb_chk.sv
// Simulation checks for the response side of vx_mem_share_arb.
module vx_mem_share_arb_chk (
  input logic clk,
  input logic reset,
  input logic rsp_valid,
  input logic rsp_idx_ok,
  input logic rsp_fire,
  input logic ost_zero
);

  a_rsp_idx_in_range: assert property (@(posedge clk) disable iff (reset)
    !(rsp_valid && !rsp_idx_ok));

  a_ost_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(rsp_fire && ost_zero));

endmodule

// File: rtl/vx_rr_arbiter.sv
// Round-robin pick: combinational priority search from a registered pointer.
module vx_rr_arbiter
  import vx_mem_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  localparam int IDX_WIDTH = idx_width(NUM_REQS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQS-1:0]  req,
  input  logic                 advance,
  output logic                 grant_valid,
  output logic [IDX_WIDTH-1:0] grant_idx
);

  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic                 hit;
  int                   j;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    hit         = 1'b0;
    j           = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      j           = (int'(ptr_q) + k) % NUM_REQS;
      hit         = req[j] && !grant_valid;
      grant_idx   = hit ? IDX_WIDTH'(j) : grant_idx;
      grant_valid = grant_valid | req[j];
    end
  end

  // Next pointer: one past the winner when a grant is taken.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_valid) begin
      ptr_d = IDX_WIDTH'((int'(grant_idx) + 1) % NUM_REQS);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vx_mem_share_arb.sv
// Shares one memory request/response port among NUM_REQS requesters with round-robin arbitration.
// Optional VX_MEM_ARB_PERF_EN adds per-requester stall-cycle counters on perf_stall_cycles.
module vx_mem_share_arb
  import vx_mem_arb_pkg::*;
#(
  parameter int NUM_REQS        = 4,
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 32,
  parameter int BYTEEN_WIDTH    = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH      = 3,
  parameter int TAG_IN_WIDTH    = 8,
  parameter int MAX_OUTSTANDING = 16,
  localparam int IDX_WIDTH      = idx_width(NUM_REQS),
  localparam int TAG_OUT_WIDTH  = TAG_IN_WIDTH + IDX_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              in_req_valid,
  input  logic [NUM_REQS-1:0]              in_req_rw,
  input  logic [NUM_REQS*BYTEEN_WIDTH-1:0] in_req_byteen,
  input  logic [NUM_REQS*SIZE_WIDTH-1:0]   in_req_size,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   in_req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   in_req_data,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] in_req_tag,
  output logic [NUM_REQS-1:0]              in_req_ready,
  output logic [NUM_REQS-1:0]              in_rsp_valid,
  output logic [NUM_REQS*DATA_WIDTH-1:0]   in_rsp_data,
  output logic [NUM_REQS*TAG_IN_WIDTH-1:0] in_rsp_tag,
  input  logic [NUM_REQS-1:0]              in_rsp_ready,
  output logic                             mem_req_valid,
  output logic                             mem_req_rw,
  output logic [BYTEEN_WIDTH-1:0]          mem_req_byteen,
  output logic [SIZE_WIDTH-1:0]            mem_req_size,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [DATA_WIDTH-1:0]            mem_req_data,
  output logic [TAG_OUT_WIDTH-1:0]         mem_req_tag,
  input  logic                             mem_req_ready,
  input  logic                             mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]         mem_rsp_tag,
  output logic                             mem_rsp_ready,
  output logic                             busy
`ifdef VX_MEM_ARB_PERF_EN
  ,
  output logic [NUM_REQS*32-1:0]           perf_stall_cycles
`endif
);

  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING) + 1;

  typedef struct packed {
    logic                     rw;
    logic [BYTEEN_WIDTH-1:0]  byteen;
    logic [SIZE_WIDTH-1:0]    size;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    data;
    logic [TAG_OUT_WIDTH-1:0] tag;
  } buf_req_t;

  logic [NUM_REQS-1:0]  eligible;
  logic                 grant_valid;
  logic [IDX_WIDTH-1:0] grant_idx;
  logic                 buf_full, push, pop;
  buf_req_t             new_req;
  buf_req_t             head_q, head_d, tail_q, tail_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] ost_q, ost_d;
  logic                 ost_inc, ost_dec;
  logic [IDX_WIDTH-1:0] rsp_idx;
  logic                 rsp_idx_ok;

  // Writes never wait on the read window; reads need a free slot.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = in_req_valid[i] && (in_req_rw[i] || (ost_q < CNT_WIDTH'(MAX_OUTSTANDING)));
    end
  end

  vx_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (eligible),
    .advance     (push),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Winner selection, grant and read-count bookkeeping.
  always_comb begin
    buf_full       = (cnt_q == 2'd2);
    push           = grant_valid && !buf_full;
    pop            = (cnt_q != 2'd0) && mem_req_ready;
    in_req_ready   = '0;
    in_req_ready[grant_idx] = push;
    new_req.rw     = in_req_rw[grant_idx];
    new_req.byteen = in_req_byteen[grant_idx*BYTEEN_WIDTH +: BYTEEN_WIDTH];
    new_req.size   = in_req_size[grant_idx*SIZE_WIDTH +: SIZE_WIDTH];
    new_req.addr   = in_req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    new_req.data   = in_req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    new_req.tag    = {grant_idx, in_req_tag[grant_idx*TAG_IN_WIDTH +: TAG_IN_WIDTH]};
    ost_inc        = push && !new_req.rw;
    ost_dec        = mem_rsp_valid && mem_rsp_ready;
    case ({ost_inc, ost_dec})
      2'b10:   ost_d = ost_q + CNT_WIDTH'(1);
      2'b01:   ost_d = (ost_q != '0) ? ost_q - CNT_WIDTH'(1) : ost_q;
      default: ost_d = ost_q;
    endcase
  end

  // Two-entry skid buffer; head always drives the memory request port.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b11: head_d = (cnt_q == 2'd2) ? tail_q : new_req;
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = new_req;
        end else begin
          tail_d = new_req;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; payload needs no reset since cnt_q qualifies it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 2'd0;
      ost_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ost_q <= ost_d;
    end
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign mem_req_valid  = (cnt_q != 2'd0);
  assign mem_req_rw     = head_q.rw;
  assign mem_req_byteen = head_q.byteen;
  assign mem_req_size   = head_q.size;
  assign mem_req_addr   = head_q.addr;
  assign mem_req_data   = head_q.data;
  assign mem_req_tag    = head_q.tag;
  assign busy           = (ost_q != '0) || (cnt_q != 2'd0);

  // Response steering by tag MSBs; a stray index is swallowed.
  always_comb begin
    rsp_idx       = mem_rsp_tag[TAG_OUT_WIDTH-1 -: IDX_WIDTH];
    rsp_idx_ok    = (int'(rsp_idx) < NUM_REQS);
    in_rsp_valid  = '0;
    mem_rsp_ready = 1'b1;
    if (rsp_idx_ok) begin
      in_rsp_valid[rsp_idx] = mem_rsp_valid;
      mem_rsp_ready         = in_rsp_ready[rsp_idx];
    end else begin
      in_rsp_valid  = '0;
      mem_rsp_ready = 1'b1;
    end
  end

  assign in_rsp_data = {NUM_REQS{mem_rsp_data}};
  assign in_rsp_tag  = {NUM_REQS{mem_rsp_tag[TAG_IN_WIDTH-1:0]}};

`ifdef VX_MEM_ARB_PERF_EN
  logic [NUM_REQS-1:0][31:0] stall_q, stall_d;

  // Saturating stall counters, one per requester.
  always_comb begin
    stall_d = stall_q;
    for (int i = 0; i < NUM_REQS; i++) begin
      stall_d[i] = (in_req_valid[i] && !in_req_ready[i] && (stall_q[i] != 32'hFFFF_FFFF))
                 ? stall_q[i] + 32'd1 : stall_q[i];
    end
  end

  // Stall counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign perf_stall_cycles = stall_q;
`endif

  vx_mem_share_arb_chk u_chk (
    .clk        (clk),
    .reset      (reset),
    .rsp_valid  (mem_rsp_valid),
    .rsp_idx_ok (rsp_idx_ok),
    .rsp_fire   (ost_dec),
    .ost_zero   (ost_q == '0)
  );

endmodule

// File: doc/vx_mem_share_arb.md
Name: vx_mem_share_arb

Overview:
Shares one Vortex memory request/response port among NUM_REQS requesters, for example several core clusters in front of a single AXI adapter.
- Round-robin arbitration on requests, with a registered request output.
- The requester index is prepended to the tag as its MSBs, so responses route back by tag.
- Tracks outstanding reads and reports busy.
- Sits between the requesters and the mem_req/mem_rsp side of the AXI adapter.

Parameters:
NUM_REQS, 4, number of requesters (≥2).
DATA_WIDTH, 512, memory data width in bits.
ADDR_WIDTH, 32, address width.
BYTEEN_WIDTH, DATA_WIDTH/8, byte-enable width.
SIZE_WIDTH, 3, request size field width.
TAG_IN_WIDTH, 8, per-requester tag width.
MAX_OUTSTANDING, 16, maximum in-flight reads (power of 2).
TAG_OUT_WIDTH, TAG_IN_WIDTH+$clog2(NUM_REQS), derived; not overridable.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_req_valid  in  NUM_REQS  per-requester request valid
in_req_rw  in  NUM_REQS  1=write, 0=read
in_req_byteen  in  NUM_REQS*BYTEEN_WIDTH  byte enables
in_req_size  in  NUM_REQS*SIZE_WIDTH  request size
in_req_addr  in  NUM_REQS*ADDR_WIDTH  address
in_req_data  in  NUM_REQS*DATA_WIDTH  write data
in_req_tag  in  NUM_REQS*TAG_IN_WIDTH  requester tag
in_req_ready  out  NUM_REQS  per-requester accept
in_rsp_valid  out  NUM_REQS  per-requester response valid
in_rsp_data  out  NUM_REQS*DATA_WIDTH  response data (broadcast)
in_rsp_tag  out  NUM_REQS*TAG_IN_WIDTH  response tag (broadcast)
in_rsp_ready  in  NUM_REQS  per-requester response accept
mem_req_valid/rw/byteen/size/addr/data  out  1/1/BYTEEN_WIDTH/SIZE_WIDTH/ADDR_WIDTH/DATA_WIDTH  shared request
mem_req_tag  out  TAG_OUT_WIDTH  {index, tag}
mem_req_ready  in  1  downstream accept
mem_rsp_valid  in  1  shared response valid
mem_rsp_data  in  DATA_WIDTH  response data
mem_rsp_tag  in  TAG_OUT_WIDTH  response tag
mem_rsp_ready  out  1  response accept
busy  out  1  reads outstanding or request buffered

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: mem_req_valid=0, in_rsp_valid=0, busy=0, rr_ptr=0, outstanding count=0; all data and tag registers are don't-care.
- Eligibility: requester i is eligible when in_req_valid[i]=1 and (in_req_rw[i]=1 or outstanding count < MAX_OUTSTANDING).
- Arbitration: the winner is the first eligible requester searching from rr_ptr upward, with wrap-around.
- Output buffer: a 2-entry skid buffer drives the mem_req_* outputs.
  - in_req_ready[winner]=1 only when the buffer is not full; all other in_req_ready bits are 0.
  - A request accepted in cycle N appears on mem_req_* in cycle N+1 (1-cycle latency).
  - With mem_req_ready held at 1, throughput is 1 request per cycle.
- Pointer update: on an accepted request, rr_ptr becomes winner+1 mod NUM_REQS. With no accept, rr_ptr holds.
- Tag construction: mem_req_tag = {winner index, in_req_tag[winner]}.
- Output stability: mem_req_* is held stable while mem_req_valid=1 and mem_req_ready=0.
- Outstanding count: increments when a read is accepted at the input, decrements on a mem_rsp handshake. Simultaneous increment and decrement leaves it unchanged. It never exceeds MAX_OUTSTANDING and never underflows.
- Response path (combinational, 0 latency):
  - idx = mem_rsp_tag MSBs.
  - in_rsp_valid[idx] = mem_rsp_valid; all other bits 0.
  - mem_rsp_ready = in_rsp_ready[idx].
  - in_rsp_tag carries the mem_rsp_tag LSBs.
- Writes produce no response.
- busy = (outstanding count ≠ 0) or (buffer non-empty).
- Reset mid-operation: buffered requests are dropped and the count is cleared. Responses arriving after reset are the system's responsibility, and are flagged in simulation by an assertion on count underflow.
- Index out of range: a response whose idx ≥ NUM_REQS is a simulation assertion error. In that case the response is dropped and mem_rsp_ready=1.

Optional Feature:
VX_MEM_ARB_PERF_EN
- Defined: adds output perf_stall_cycles (NUM_REQS*32 bits). Counter i increments each cycle that in_req_valid[i]=1 and in_req_ready[i]=0, saturates at 2^32-1, and clears on reset.
- Undefined: the port and the counters are absent.

Decomposition:
- Package vx_mem_arb_pkg: IDX_WIDTH = $clog2(NUM_REQS) helper function, plus a packed req_t struct {rw, byteen, size, addr, data, tag}.
- Sub-module vx_rr_arbiter: a combinational priority pick with a registered pointer; reusable across the design.
- The skid buffer is built inline.

Test Plan:
- All 4 requesters issue reads continuously, mem_req_ready=1 → grants are 0,1,2,3,0… on consecutive cycles; mem_req_tag MSBs match; mem_req_valid rises 1 cycle after the first accept.
- Requester 2 issues 16 reads with MAX_OUTSTANDING=16 and no responses → the 17th read stalls (in_req_ready[2]=0); a write from requester 2 is still accepted; busy=1.
- mem_req_ready held at 0 for 5 cycles with 2 buffered requests → in_req_ready is all 0, mem_req_* stays stable, and no request is lost after release.
- Response with mem_rsp_tag={2'd3, 8'hA5} and in_rsp_ready[3]=0 for 2 cycles → mem_rsp_ready=0 for those cycles, then a handshake completes; in_rsp_tag=8'hA5 and only in_rsp_valid[3] is asserted.
- Read accepted and response handshake in the same cycle with the count at 5 → the count stays at 5.
- Reset asserted with 3 reads outstanding and 1 request buffered → the next cycle shows mem_req_valid=0, busy=0, rr_ptr=0.
